// File: rtl/ram4_if.sv
// ---------------------------------------------------------------------------
// ram4_if
// Purpose : Bundles the data/control bus of the 4-word x 16-bit RAM so that
//           the driver side and the RAM side can be connected as a unit.
// Signals : in      [15:0]  write data            (master -> slave)
//           load            write enable          (master -> slave)
//           address [1:0]   word select, read+wr  (master -> slave)
//           out     [15:0]  read data             (slave  -> master)
// Modports: master - whoever drives the RAM (testbench, CPU datapath, ...)
//           slave  - the RAM itself
// ---------------------------------------------------------------------------
interface ram4_if;

    logic [15:0] in;
    logic        load;
    logic [1:0]  address;
    logic [15:0] out;

    // The driving side owns data, enable and address and observes read data.
    modport master (
        output in,
        output load,
        output address,
        input  out
    );

    // The RAM consumes data, enable and address and produces read data.
    modport slave (
        input  in,
        input  load,
        input  address,
        output out
    );

endinterface

// File: rtl/ram4.sv
// ---------------------------------------------------------------------------
// ram4
// Purpose : Four-word, 16-bit register RAM. Writes happen on the rising edge
//           of clk when load is high; reads are purely combinational through
//           a 4-way 16-bit multiplexer, so a write at edge N is visible on
//           out straight after edge N.
// Ports   : clk            single clock, all state changes on rising edge
//           reset          synchronous, active-high; clears all words and
//                          wins over a simultaneous write
//           bus (slave)    in / load / address / out, see ram4_if
//
// mux4way16
// Purpose : Combinational 4:1 selector for 16-bit words, used as the RAM read
//           path.
// Ports   : i_a..i_d [15:0] candidate words (sel 00..11)
//           i_sel    [1:0]  select
//           o_out    [15:0] selected word
// ---------------------------------------------------------------------------
module mux4way16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [15:0] i_c,
    input  logic [15:0] i_d,
    input  logic [1:0]  i_sel,
    output logic [15:0] o_out
);

    // Plain 4:1 select; the default keeps the block latch-free even though
    // all four select codes are listed.
    always_comb begin
        o_out = i_a;
        case (i_sel)
            2'b00:   o_out = i_a;
            2'b01:   o_out = i_b;
            2'b10:   o_out = i_c;
            2'b11:   o_out = i_d;
            default: o_out = i_a;
        endcase
    end

endmodule

module ram4 (
    input  logic  clk,
    input  logic  reset,
    ram4_if.slave bus
);

    logic [15:0] r_word0;
    logic [15:0] r_word1;
    logic [15:0] r_word2;
    logic [15:0] r_word3;

    logic [3:0]  w_wrEn;
    logic [15:0] w_readData;

    // Route the single write enable to exactly one word. With load low no
    // enable is raised, so every word holds regardless of in or address.
    always_comb begin
        w_wrEn = 4'b0000;
        if (bus.load) begin
            case (bus.address)
                2'b00:   w_wrEn = 4'b0001;
                2'b01:   w_wrEn = 4'b0010;
                2'b10:   w_wrEn = 4'b0100;
                2'b11:   w_wrEn = 4'b1000;
                default: w_wrEn = 4'b0000;
            endcase
        end
    end

    // Word storage. Reset is checked first so that a write arriving in the
    // same cycle as reset is discarded and all four words clear together.
    // Only the values of in/address present at the rising edge matter, since
    // nothing here is sensitive to them between edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word0 <= 16'h0000;
            r_word1 <= 16'h0000;
            r_word2 <= 16'h0000;
            r_word3 <= 16'h0000;
        end else begin
            if (w_wrEn[0]) r_word0 <= bus.in;
            if (w_wrEn[1]) r_word1 <= bus.in;
            if (w_wrEn[2]) r_word2 <= bus.in;
            if (w_wrEn[3]) r_word3 <= bus.in;
        end
    end

    // Read path is combinational from the stored words, so an address change
    // shows up on out within the same cycle and a freshly written word is
    // visible right after its edge.
    mux4way16 u_readMux (
        .i_a   (r_word0),
        .i_b   (r_word1),
        .i_c   (r_word2),
        .i_d   (r_word3),
        .i_sel (bus.address),
        .o_out (w_readData)
    );

    assign bus.out = w_readData;

endmodule

// File: tb/tb_ram4.sv
// ---------------------------------------------------------------------------
// tb_ram4
// Purpose : Self-checking bench for ram4. A reference array tracks the four
//           words; every stimulus step pushes the value out should show onto
//           an expectation queue, and the entry is popped and compared once
//           the DUT output has settled.
// ---------------------------------------------------------------------------
module tb_ram4;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } expItem_t;

    logic        clk;
    logic        reset;
    ram4_if      bus ();

    logic [15:0] model [4];
    expItem_t    expQ  [$];
    int          checkCount;
    int          errCount;

    ram4 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h required %h", tag, observed, expected);
        end
    endtask

    // Pop the oldest expectation and compare it with what out shows now.
    task automatic compareNext();
        expItem_t e;
        if (expQ.size() == 0) begin
            checkOutput("sbUnderflow", 16'(expQ.size()), 16'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput(e.tag, bus.out, e.val);
        end
    endtask

    // One clocked step: drive after the falling edge, update the model at the
    // rising edge (reset beats load), then check out just after the edge.
    task automatic applyStimulus(input logic rst, input logic ld,
                                 input logic [1:0] addr, input logic [15:0] data,
                                 input string tag);
        @(negedge clk);
        reset       = rst;
        bus.load    = ld;
        bus.address = addr;
        bus.in      = data;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) model[i] = 16'h0000;
        end else if (ld) begin
            model[addr] = data;
        end
        expQ.push_back('{tag, model[addr]});
        #1;
        compareNext();
    endtask

    // Combinational read: change address mid-cycle with load low, check out
    // before the next edge.
    task automatic readCheck(input logic [1:0] addr, input string tag);
        @(negedge clk);
        reset       = 1'b0;
        bus.load    = 1'b0;
        bus.address = addr;
        bus.in      = 16'h0F0F;
        #1;
        expQ.push_back('{tag, model[addr]});
        compareNext();
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 4; a++) readCheck(2'(a), $sformatf("%s%0d", tag, a));
    endtask

    initial begin
        logic [15:0] wrVals [4];
        logic [1:0]  ra;
        logic [15:0] rd;
        logic        rl;
        logic        rr;

        checkCount  = 0;
        errCount    = 0;
        reset       = 1'b1;
        bus.load    = 1'b0;
        bus.address = 2'b00;
        bus.in      = 16'h0000;
        for (int i = 0; i < 4; i++) model[i] = 16'h0000;

        // Reset, then every address reads zero.
        applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, "reset");
        sweep("rstSweep");

        // Write four patterns and read them back in order.
        wrVals[0] = 16'h5500;
        wrVals[1] = 16'hAA00;
        wrVals[2] = 16'h0055;
        wrVals[3] = 16'h00AA;
        for (int a = 0; a < 4; a++)
            applyStimulus(1'b0, 1'b1, 2'(a), wrVals[a], $sformatf("wr%0d", a));
        sweep("rdBack");

        // Read-during-write on address 2: old value before the edge, new after.
        @(negedge clk);
        reset       = 1'b0;
        bus.load    = 1'b1;
        bus.address = 2'd2;
        bus.in      = 16'hFFFF;
        #1;
        expQ.push_back('{"rdwOld", 16'h0055});
        compareNext();
        @(posedge clk);
        model[2] = 16'hFFFF;
        #1;
        expQ.push_back('{"rdwNew", 16'hFFFF});
        compareNext();
        readCheck(2'd0, "rdwKeep0");
        readCheck(2'd1, "rdwKeep1");
        readCheck(2'd3, "rdwKeep3");

        // load low for several edges: word1 stays 16'hAA00.
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b0, 1'b0, 2'd1, 16'h1234, $sformatf("noLoad%0d", k));

        // in/address change while load is high: only the edge-time values count.
        @(negedge clk);
        bus.load    = 1'b1;
        bus.address = 2'd0;
        bus.in      = 16'h1111;
        #2;
        bus.address = 2'd3;
        bus.in      = 16'h7777;
        @(posedge clk);
        model[3] = 16'h7777;
        #1;
        expQ.push_back('{"lateInput", 16'h7777});
        compareNext();
        readCheck(2'd0, "lateKeep0");

        // Plain reset mid-operation clears every word.
        applyStimulus(1'b1, 1'b0, 2'd2, 16'h0000, "midReset");
        sweep("midRstSweep");

        // Rewrite, then reset together with a write: reset wins.
        applyStimulus(1'b0, 1'b1, 2'd3, 16'h1357, "preRst3");
        applyStimulus(1'b1, 1'b1, 2'd3, 16'hBEEF, "rstLoad");
        sweep("rstLoadSweep");

        // Writes resume on the first edge with reset low.
        applyStimulus(1'b0, 1'b1, 2'd1, 16'hCAFE, "resume");
        readCheck(2'd1, "resumeRd");

        // Full-width extremes on address 0, consecutive edges.
        applyStimulus(1'b0, 1'b1, 2'd0, 16'h0000, "wrZero");
        applyStimulus(1'b0, 1'b1, 2'd0, 16'hFFFF, "wrOnes");
        readCheck(2'd3, "onesKeep3");
        readCheck(2'd1, "onesKeep1");

        // Random mix of writes, idles and occasional resets against the model.
        for (int k = 0; k < 40; k++) begin
            ra = 2'($urandom_range(0, 3));
            rd = 16'($urandom);
            rl = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 15) == 0);
            applyStimulus(rr, rl, ra, rd, $sformatf("rnd%0d", k));
            readCheck(2'($urandom_range(0, 3)), $sformatf("rndRd%0d", k));
        end
        sweep("finalSweep");

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ram4.md
RAM4 -- requirements
Module: ram4

Interface
REQ-001 Parameters: none; data width fixed at 16 bits, depth fixed at 4 words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-004 in  input  16  write data.
REQ-005 load  input  1  write enable; when high at a rising edge, in is written to word[address].
REQ-006 address  input  2  word select for both read and write.
REQ-007 out  output  16  read data = contents of word[address].
REQ-008 One clock; reset is synchronous and active-high.

Function
REQ-009 Storage: four 16-bit registers, word0..word3, each updated only on a rising edge of clk.
REQ-010 Write decode: load routed to exactly one word by address (00->word0, 01->word1, 10->word2, 11->word3); the other three words hold.
REQ-011 Write latency: data written at edge N visible on out from immediately after edge N (zero added cycles).
REQ-012 Read path: combinational; out = word[address] with no clock dependency; address change updates out in the same cycle.
REQ-013 Read path built from a mux4way16 instance: a=word0, b=word1, c=word2, d=word3, sel=address.
REQ-014 Read-during-write, same address: before the edge out shows the old value; after the edge, the new value.
REQ-015 Read-during-write, different address: out unaffected by the write.
REQ-016 load low: no word changes, regardless of in or address.
REQ-017 in and address changing between edges with load high: only values present at the rising edge are written.
REQ-018 Priority at an edge: reset > load; reset and load both high clears all words and discards the write.
REQ-019 Full 16-bit data preserved: 16'h0000 and 16'hFFFF written and read back bit-exact; no sign or width conversion.
REQ-020 No X propagation after reset: out always a defined value once reset has been applied for one edge.

Reset
REQ-021 reset high at a rising edge: word0..word3 SHALL all become 16'h0000 at that edge.
REQ-022 After reset, out SHALL read 16'h0000 for every address until a write occurs.
REQ-023 reset asserted mid-operation (after arbitrary writes) SHALL clear all four words at the next edge; no partial clear.
REQ-024 reset deasserted: normal writes SHALL resume at the first edge with reset low.
REQ-025 Before the first reset, contents are undefined; the bench SHALL apply reset before checking.

Verification
REQ-026 Reset then sweep address 0..3 with load=0 -> out == 16'h0000 for every address.
REQ-027 Write 16'h5500, 16'hAA00, 16'h0055, 16'h00AA to addresses 0,1,2,3 (load=1, one edge each), then load=0 and sweep address 0..3 -> out reads back each value in order.
REQ-028 address=2 holding 16'h0055, in=16'hFFFF, load=1: before the edge out == 16'h0055; after the edge out == 16'hFFFF; words 0,1,3 unchanged.
REQ-029 load=0, in=16'h1234, address=1, several edges -> word1 unchanged (16'hAA00).
REQ-030 reset=1 and load=1 (address=3, in=16'hBEEF) at the same edge -> all words 16'h0000; address=3 reads 16'h0000, not 16'hBEEF.
REQ-031 Write 16'h0000 then 16'hFFFF to address 0 on consecutive edges -> out == 16'h0000 after the first, 16'hFFFF after the second.
